i2c_target_module: RTL
======================

// Module: i2c_target_module
// PURPOSE
//  I2C target (slave) engine: the responder end of the bus our I2C master drives.
//  Oversamples SCL/SDA on the FPGA clock, detects START/STOP, matches a 7-bit device address,
//  ACKs and receives write bytes, and shifts out read bytes on request.
//  Used to build on-board EEPROM emulators and self-test loops for the M24Cxx programmer paths.
// PARAMETERS
//  DEV_ADDR   7'h50  device address compared against the received address
//  ADDR_MASK  7'h78  1-bits are compared; 0-bits are don't-care (M24C16 block bits A2..A0)
// PORTS
//  clock        in   1  system clock, >= 8x SCL frequency
//  reset        in   1  asynchronous, active-high reset
//  scl_in       in   1  SCL pin level (asynchronous)
//  sda_in       in   1  SDA pin level (asynchronous)
//  sda_out_en   out  1  1 = pull SDA low (open drain); 0 = release
//  addr_rx      out  7  last matched address, bits [6:0]
//  busy         out  1  1 while addressed (ADDR_ACK..TX_ACK states)
//  rx_data      out  8  received write byte, valid with rx_valid
//  rx_valid     out  1  1-cycle pulse per received data byte
//  rx_first     out  1  qualifies rx_valid: first data byte after the address
//  tx_req       out  1  1-cycle pulse: present next read byte on tx_data
//  tx_data      in   8  read byte; sampled on the SCL falling edge ending the ACK bit
//  start_det    out  1  1-cycle pulse on START or repeated START
//  stop_det     out  1  1-cycle pulse on STOP
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; SDA released; shift register and bit count 0.
//  - Pins pass a 2-FF synchronizer; edges = synced vs previous synced value (3-cycle latency).
//  - START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both act in any state,
//    take priority over SCL-edge processing in the same cycle, and release SDA immediately.
//    START -> ADDR, bit count 0. STOP -> IDLE.
//  - States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
//  - Bits are sampled on SCL rising, MSB first; SDA is changed only on SCL falling.
//  - ADDR: after the 8th rising edge compare (addr ^ DEV_ADDR) & ADDR_MASK == 0.
//    Match: on the next SCL fall assert sda_out_en, latch addr_rx, enter ADDR_ACK.
//    Mismatch: enter WAIT_STOP; SDA stays released.
//  - ADDR_ACK: if R/W=1, pulse tx_req on entry. On the SCL fall ending the ACK bit:
//    read -> load tx_data, drive bit7 (sda_out_en = ~bit), enter TX;
//    write -> release SDA, enter RX.
//  - RX: on the 8th rising edge pulse rx_valid with rx_data. rx_first=1 only for the first
//    byte since the address. Next SCL fall: assert ACK, enter RX_ACK.
//    Following fall: release SDA, enter RX.
//  - TX: drive one bit per SCL fall. After the 8th bit's fall, release SDA, enter TX_ACK.
//    At the TX_ACK rising edge:
//    SDA=0 (ACK) -> pulse tx_req; next fall loads tx_data, enters TX.
//    SDA=1 (NACK) -> WAIT_STOP, SDA released.
//  - WAIT_STOP: ignore SCL; leave only on START or STOP.
//  - A START in any state aborts the byte in progress: no rx_valid, no tx_req.
//  - Reset mid-transfer releases SDA asynchronously in the same instant.
//  - No clock stretching: SCL is never driven.
// TESTING
//  1 START,0xA0,0x12,0x34,STOP -> ACK x3; rx_valid x2: 0x12 with rx_first=1, then 0x34 with
//    rx_first=0; start_det then stop_det
//  2 START,0x90,0x55 -> SDA released in both 9th clocks; no rx_valid; busy=0; next START,0xA0
//    -> ACK
//  3 START,0xA1; tx_data 0x5A then 0xC3; master ACK then NACK -> SDA carries 0x5A,0xC3;
//    2 tx_req pulses; SDA released after the NACK
//  4 START,0xA0,0x05,Sr,0xA1, read 1 byte with NACK -> rx_valid 0x05; 2 start_det pulses;
//    1 byte returned
//  5 START,0xAE (ADDR_MASK 7'h78) -> ACK; addr_rx=7'h57
//  6 reset asserted while TX drives bit=0 -> sda_out_en=0 immediately; no further bus
//    activity until START

Source files
------------

// File: rtl/i2c_target_module.sv
// I2C target engine: oversampled SCL/SDA, START/STOP detection, masked 7-bit address match,
// write-byte reception with ACK and read-byte transmission on request.
module i2c_target_module #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter logic [6:0] ADDR_MASK = 7'h78
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_out_en_o,
  output logic [6:0] addr_rx_o,
  output logic       busy_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       start_det_o,
  output logic       stop_det_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_WAIT_STOP
  } state_e;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic [6:0] addr_rx_q, addr_rx_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  logic scl_rise, scl_fall, start_cond, stop_cond, addr_match;

  // NOTE: the synchronizer stages reset to the idle-bus level (1) so that leaving reset
  // with both lines high is not mistaken for an SDA or SCL edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise   = scl_sync_q & ~scl_prev_q;
  assign scl_fall   = ~scl_sync_q & scl_prev_q;
  // SCL must be stably high across the SDA transition to qualify as START/STOP.
  assign start_cond = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_cond  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign addr_match = ((shift_q[6:0] ^ DEV_ADDR) & ADDR_MASK) == 7'd0;

  // NOTE: every state register is reset here, including sda_oe_q, so asserting reset
  // releases SDA in the same instant without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 4'd0;
      sda_oe_q   <= 1'b0;
      addr_rx_q  <= 7'd0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      addr_rx_q  <= addr_rx_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    addr_rx_d  = addr_rx_q;
    rw_d       = rw_q;
    first_d    = first_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;

    if (start_cond) begin
      state_d   = S_ADDR;
      shift_d   = 8'd0;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      first_d   = 1'b1;
      start_d   = 1'b1;
    end else if (stop_cond) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      stop_d    = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && !addr_match) state_d = S_WAIT_STOP;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            addr_rx_d = shift_q[7:1];
            rw_d      = shift_q[0];
            tx_req_d  = shift_q[0];
            state_d   = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              shift_d   = tx_data_i;
              sda_oe_d  = ~tx_data_i[7];
              bit_cnt_d = 4'd1;
              state_d   = S_TX;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_valid_d = 1'b1;
              rx_data_d  = {shift_q[6:0], sda_sync_q};
              rx_first_d = first_q;
              first_d    = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_RX;
          end
        end
        S_TX: begin
          // bit_cnt_q counts bits already placed on SDA; the load counted bit 7.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_TX_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            if (sda_sync_q) state_d = S_WAIT_STOP;
            else            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            shift_d   = tx_data_i;
            sda_oe_d  = ~tx_data_i[7];
            bit_cnt_d = 4'd1;
            state_d   = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_out_en_o = sda_oe_q;
  assign addr_rx_o    = addr_rx_q;
  assign busy_o       = state_q inside {S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK};
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_first_o   = rx_first_q;
  assign tx_req_o     = tx_req_q;
  assign start_det_o  = start_q;
  assign stop_det_o   = stop_q;

endmodule
